regfile_flags: RTL and testbench
================================

Name: regfile_flags

Overview:
- Register file plus status-flag register directly upstream of the ALU in the 16-bit datapath.
- Supplies the ALU's rs/rt operands from two combinational read ports.
- Accepts the ALU result rd and the ALU flags N/Z/C/P on a single write port.
- Evaluates a 3-bit branch condition against the stored flags for the branch unit.

Parameters:
- NREGS, 16, number of 16-bit general registers; address width is log2(NREGS); must be a power of two.
- WIDTH, 16, register data width; matches the ALU operand and result width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ra_addr  input  4  read port A address; drives the ALU rs operand.
- rb_addr  input  4  read port B address; drives the ALU rt operand.
- ra_data  output  16  read port A data.
- rb_data  output  16  read port B data.
- w_en  input  1  register write enable.
- w_addr  input  4  write address.
- w_data  input  16  write data; the ALU rd.
- flag_we  input  1  flag register write enable.
- fN_in, fZ_in, fC_in, fP_in  input  1 each  ALU flag outputs.
- flags  output  4  stored flags, {N,Z,C,P} with N at bit 3.
- cond  input  3  branch condition code.
- cond_true  output  1  condition result.

Behaviour:
- Reset (asynchronous assert, synchronous release on the next clk edge):
  - All registers R0..R(NREGS-1) clear to 0x0000.
  - flags clears to 4'b0000.
  - While rst_n is low, ra_data and rb_data read 0x0000, and cond_true = 1 for cond=000, 0 for every other code.
- R0 is hardwired to zero:
  - Reads of address 0 always return 0x0000.
  - Writes to address 0 are discarded, including when the bypass would otherwise apply.
- Write: on the rising clk with w_en=1 and w_addr!=0, R[w_addr] <= w_data.
- Read ports: combinational, zero latency.
  - ra_data = R[ra_addr] and rb_data = R[rb_addr].
  - Write-through bypass: if w_en=1, w_addr!=0 and w_addr equals a read address, that port returns w_data in the same cycle, before the edge.
  - Both ports may read the same address simultaneously; both see identical data, bypass included.
- Flags: on the rising clk with flag_we=1, flags <= {fN_in,fZ_in,fC_in,fP_in}.
  - flag_we and w_en are independent; either, both or neither may be set in a cycle.
  - flags holds its value when flag_we=0.
- Condition evaluation: combinational, registered flags only (no flag bypass).
  - A flag write in cycle t is visible to cond_true from cycle t+1.
  - Codes:
    - 000 always -> 1
    - 001 EQ -> Z
    - 010 NE -> !Z
    - 011 MI -> N
    - 100 PL -> P
    - 101 CS -> C
    - 110 CC -> !C
    - 111 never -> 0
- Address width: if NREGS < 16, the upper address bits are ignored; address wraps modulo NREGS.
- Reset mid-operation: a write presented in the same cycle that rst_n falls is lost; all state is zero after reset.
- No X propagation: with no writes since reset, every read port is 0x0000.

Test Plan:
- Reset, then read all 16 addresses on both ports -> every read 0x0000, flags=0000, cond_true=1 for cond=000 and 0 for cond=001..111.
- Write R1=0x0001, R2=0x0002 on consecutive edges; then ra_addr=1, rb_addr=2 -> ra_data=0x0001, rb_data=0x0002 (the ALU ADD operands).
- Write R5=0xBEEF with ra_addr=5, rb_addr=5 in the same cycle -> both ports show 0xBEEF before the edge (bypass); R5 holds 0xBEEF afterwards with w_en=0.
- w_en=1, w_addr=0, w_data=0xFFFF with ra_addr=0 -> ra_data=0x0000 before and after the edge.
- flag_we=1 with Z_in=1 (result of 1-1 SUB), others 0, and cond=001 -> cond_true=0 in the write cycle, flags=0100 and cond_true=1 on the next cycle; cond=010 then gives 0.
- Write R3=0x1234, then pulse rst_n low between clock edges -> ra_data for R3 reads 0x0000 and flags=0000 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/regfile_flags.sv
// Register file with R0 tied to zero, write-through bypass on both read ports,
// and a {N,Z,C,P} flag register feeding a 3-bit branch-condition evaluator.
module regfile_flags #(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ra_addr,
    input  logic [3:0]       rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             w_en,
    input  logic [3:0]       w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             flag_we,
    input  logic             fN_in,
    input  logic             fZ_in,
    input  logic             fC_in,
    input  logic             fP_in,
    output logic [3:0]       flags,
    input  logic [2:0]       cond,
    output logic             cond_true
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] regs_r [NREGS];
    logic [3:0]       flags_r;
    logic [AW-1:0]    ra_idx_s;
    logic [AW-1:0]    rb_idx_s;
    logic [AW-1:0]    w_idx_s;
    logic             w_live_s;
    logic [WIDTH-1:0] ra_data_s;
    logic [WIDTH-1:0] rb_data_s;
    logic             cond_true_s;

    // Address decode: upper address bits are dropped so smaller files wrap.
    always_comb begin
        ra_idx_s = ra_addr[AW-1:0];
        rb_idx_s = rb_addr[AW-1:0];
        w_idx_s  = w_addr[AW-1:0];
        if (w_en && (w_idx_s != '0)) begin
            w_live_s = 1'b1;
        end else begin
            w_live_s = 1'b0;
        end
    end

    // Register array and flag register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
            flags_r <= 4'b0000;
        end else begin
            if (w_live_s) begin
                regs_r[w_idx_s] <= w_data;
            end
            if (flag_we) begin
                flags_r <= {fN_in, fZ_in, fC_in, fP_in};
            end
        end
    end

    // Read port A: reset forces zero, R0 reads zero, pending write is bypassed.
    always_comb begin
        ra_data_s = '0;
        if (!rst_n) begin
            ra_data_s = '0;
        end else if (ra_idx_s == '0) begin
            ra_data_s = '0;
        end else if (w_live_s && (w_idx_s == ra_idx_s)) begin
            ra_data_s = w_data;
        end else begin
            ra_data_s = regs_r[ra_idx_s];
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rb_data_s = '0;
        if (!rst_n) begin
            rb_data_s = '0;
        end else if (rb_idx_s == '0) begin
            rb_data_s = '0;
        end else if (w_live_s && (w_idx_s == rb_idx_s)) begin
            rb_data_s = w_data;
        end else begin
            rb_data_s = regs_r[rb_idx_s];
        end
    end

    // Branch condition from stored flags only; in reset only "always" is true.
    always_comb begin
        cond_true_s = 1'b0;
        if (!rst_n) begin
            cond_true_s = (cond == 3'd0);
        end else begin
            case (cond)
                3'd0:    cond_true_s = 1'b1;
                3'd1:    cond_true_s = flags_r[2];
                3'd2:    cond_true_s = ~flags_r[2];
                3'd3:    cond_true_s = flags_r[3];
                3'd4:    cond_true_s = flags_r[0];
                3'd5:    cond_true_s = flags_r[1];
                3'd6:    cond_true_s = ~flags_r[1];
                3'd7:    cond_true_s = 1'b0;
                default: cond_true_s = 1'b0;
            endcase
        end
    end

    assign ra_data   = ra_data_s;
    assign rb_data   = rb_data_s;
    assign flags     = flags_r;
    assign cond_true = cond_true_s;

endmodule

// File: tb/tb_regfile_flags.sv
// Self-checking bench for regfile_flags: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_regfile_flags;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ra_addr, rb_addr, w_addr;
    logic [15:0] ra_data, rb_data, w_data;
    logic        w_en, flag_we;
    logic        fN_in, fZ_in, fC_in, fP_in;
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic        cond_true;

    int vectors;
    int miscompares;

    logic [15:0] mdl [16];
    logic [3:0]  mflags;

    regfile_flags #(.NREGS(16), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .flag_we(flag_we),
        .fN_in(fN_in), .fZ_in(fZ_in), .fC_in(fC_in), .fP_in(fP_in),
        .flags(flags), .cond(cond), .cond_true(cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_read(input logic [3:0] a);
        if (a == 4'd0) return 16'h0000;
        if (w_en && (w_addr != 4'd0) && (w_addr == a)) return w_data;
        return mdl[a];
    endfunction

    function automatic logic exp_cond(input logic [2:0] c, input logic [3:0] f);
        logic n, z, cy, p;
        n = f[3]; z = f[2]; cy = f[1]; p = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return p;
            3'd5: return cy;
            3'd6: return !cy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        w_en = 1'b0; w_addr = 4'd0; w_data = 16'h0000;
        flag_we = 1'b0; fN_in = 1'b0; fZ_in = 1'b0; fC_in = 1'b0; fP_in = 1'b0;
        ra_addr = 4'd0; rb_addr = 4'd0; cond = 3'd0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        mflags = 4'b0000;
    endtask

    // Advance one rising edge, updating the model from the inputs presented.
    task automatic edge_commit();
        @(posedge clk);
        if (w_en && w_addr != 4'd0) mdl[w_addr] = w_data;
        if (flag_we) mflags = {fN_in, fZ_in, fC_in, fP_in};
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        clear_model();
        w_en = 1'b1; w_addr = 4'd5; w_data = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            ra_addr = a[3:0]; rb_addr = 4'(15 - a);
            #1;
            vectors++;
            if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d ra=%h rb=%h required 0000/0000", a, ra_data, rb_data);
            end
        end
        vectors++;
        if (flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b required 0000", flags);
        end
        for (int c = 0; c < 8; c++) begin
            cond = c[2:0];
            #1;
            vectors++;
            if (cond_true !== (c == 0)) begin
                miscompares++;
                $display("FAIL reset_cond cond=%0d got %b required %b", c, cond_true, (c == 0));
            end
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ra_addr = 4'd5;
        #1;
        vectors++;
        if (ra_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_write_lost R5 got %h required 0000", ra_data);
        end
    endtask

    task automatic test_add_operands();
        @(negedge clk);
        w_en = 1'b1; w_addr = 4'd1; w_data = 16'h0001;
        edge_commit();
        @(negedge clk);
        w_addr = 4'd2; w_data = 16'h0002;
        edge_commit();
        @(negedge clk);
        idle_inputs();
        ra_addr = 4'd1; rb_addr = 4'd2;
        #1;
        vectors++;
        if (ra_data !== 16'h0001 || rb_data !== 16'h0002) begin
            miscompares++;
            $display("FAIL add_operands ra=%h rb=%h required 0001/0002", ra_data, rb_data);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        w_en = 1'b1; w_addr = 4'd5; w_data = 16'hBEEF;
        ra_addr = 4'd5; rb_addr = 4'd5;
        #1;
        vectors++;
        if (ra_data !== 16'hBEEF || rb_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL bypass_pre ra=%h rb=%h required beef/beef", ra_data, rb_data);
        end
        edge_commit();
        @(negedge clk);
        w_en = 1'b0; w_data = 16'h0000;
        #1;
        vectors++;
        if (ra_data !== 16'hBEEF || rb_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL bypass_hold ra=%h rb=%h required beef/beef", ra_data, rb_data);
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        w_en = 1'b1; w_addr = 4'd0; w_data = 16'hFFFF;
        ra_addr = 4'd0; rb_addr = 4'd0;
        #1;
        vectors++;
        if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL r0_pre ra=%h rb=%h required 0000", ra_data, rb_data);
        end
        edge_commit();
        @(negedge clk);
        w_en = 1'b0;
        #1;
        vectors++;
        if (ra_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL r0_post ra=%h required 0000", ra_data);
        end
    endtask

    task automatic test_flags();
        @(negedge clk);
        flag_we = 1'b1; fN_in = 1'b0; fZ_in = 1'b1; fC_in = 1'b0; fP_in = 1'b0;
        cond = 3'd1;
        #1;
        vectors++;
        if (cond_true !== 1'b0) begin
            miscompares++;
            $display("FAIL flag_no_bypass cond_true=%b required 0", cond_true);
        end
        edge_commit();
        @(negedge clk);
        flag_we = 1'b0; fZ_in = 1'b0;
        #1;
        vectors++;
        if (flags !== 4'b0100 || cond_true !== 1'b1) begin
            miscompares++;
            $display("FAIL flag_eq flags=%b cond_true=%b required 0100/1", flags, cond_true);
        end
        cond = 3'd2;
        #1;
        vectors++;
        if (cond_true !== 1'b0) begin
            miscompares++;
            $display("FAIL flag_ne cond_true=%b required 0", cond_true);
        end
        edge_commit();
        vectors++;
        if (flags !== 4'b0100) begin
            miscompares++;
            $display("FAIL flag_hold flags=%b required 0100", flags);
        end
    endtask

    task automatic test_random();
        logic [31:0] rnd;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rnd = $urandom;
            w_en = rnd[0]; flag_we = rnd[1];
            fN_in = rnd[2]; fZ_in = rnd[3]; fC_in = rnd[4]; fP_in = rnd[5];
            cond = rnd[8:6]; w_addr = rnd[12:9];
            ra_addr = rnd[16:13]; rb_addr = rnd[20:17];
            if (rnd[21]) ra_addr = w_addr;
            if (rnd[22]) rb_addr = ra_addr;
            rnd = $urandom;
            w_data = rnd[15:0];
            #1;
            vectors++;
            if (ra_data !== exp_read(ra_addr) || rb_data !== exp_read(rb_addr)) begin
                miscompares++;
                $display("FAIL rand_read n=%0d ra[%0d]=%h rb[%0d]=%h required %h/%h",
                         n, ra_addr, ra_data, rb_addr, rb_data, exp_read(ra_addr), exp_read(rb_addr));
            end
            vectors++;
            if (flags !== mflags || cond_true !== exp_cond(cond, mflags)) begin
                miscompares++;
                $display("FAIL rand_flags n=%0d flags=%b cond=%0d ct=%b required %b/%b",
                         n, flags, cond, cond_true, mflags, exp_cond(cond, mflags));
            end
            edge_commit();
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle_inputs();
        w_en = 1'b1; w_addr = 4'd3; w_data = 16'h1234;
        flag_we = 1'b1; fN_in = 1'b1; fC_in = 1'b1;
        edge_commit();
        @(negedge clk);
        idle_inputs();
        ra_addr = 4'd3;
        #1;
        vectors++;
        if (ra_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL pre_reset R3 got %h required 1234", ra_data);
        end
        #1;
        w_en = 1'b1; w_addr = 4'd7; w_data = 16'hA5A5;
        rst_n = 1'b0;
        clear_model();
        #1;
        vectors++;
        if (ra_data !== 16'h0000 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset R3=%h flags=%b required 0000/0000", ra_data, flags);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        ra_addr = 4'd7; rb_addr = 4'd3;
        #1;
        vectors++;
        if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_write R7=%h R3=%h required 0000/0000", ra_data, rb_data);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_add_operands();
        test_bypass();
        test_r0();
        test_flags();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
